// File: rtl/hazard_control_unit_if.sv
// Interface between the pipeline datapath and the hazard control unit.
// The master side is the pipeline; the slave side is the hazard controller.
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_mem_read;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             dmem_timeout;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd, id_ex_mem_read,
           ex_branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
           id_ex_flush, mem_wb_bubble, dmem_timeout, ctrl_state, stall_count,
           flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd, id_ex_mem_read,
           ex_branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
           id_ex_flush, mem_wb_bubble, dmem_timeout, ctrl_state, stall_count,
           flush_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, dmem-wait
// freeze with a watchdog, and saturating stall/flush counters.
//
// state    | meaning
// RUN      | normal flow; hazards resolved combinationally
// MEM_WAIT | data memory busy; pipeline frozen, wait_cnt counts busy cycles
// TIMEOUT  | watchdog expired; pipeline frozen until reset
module hazard_control_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_control_unit_if.slave bus
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    TIMEOUT  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             timeout_flag, timeout_flag_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic load_use, mem_busy;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, mem_wb_bubble;

  assign mem_busy = bus.dmem_req & ~bus.dmem_ready;
  assign load_use = bus.id_ex_mem_read && (bus.id_ex_rd != 5'd0) &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == bus.id_ex_rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == bus.id_ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      timeout_flag <= timeout_flag_nxt;
      if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (if_id_flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nxt        = state;
    wait_cnt_nxt     = wait_cnt;
    timeout_flag_nxt = timeout_flag;
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    id_ex_write      = 1'b1;
    ex_mem_write     = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;
    mem_wb_bubble    = 1'b0;

    unique case (state)
      RUN: begin
        if (mem_busy) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt        = TIMEOUT;
          timeout_flag_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      TIMEOUT: ;
      default: state_nxt = RUN;
    endcase

    // While reset is asserted the controls stay at their pass-through values.
    if (rst_n) begin
      if (mem_busy || (state == TIMEOUT)) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (bus.ex_branch_taken) begin
        // The load-use consumer sits in ID and is flushed anyway.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.if_id_write   = if_id_write;
  assign bus.id_ex_write   = id_ex_write;
  assign bus.ex_mem_write  = ex_mem_write;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.dmem_timeout  = timeout_flag;
  assign bus.ctrl_state    = state;
  assign bus.stall_count   = stall_cnt;
  assign bus.flush_count   = flush_cnt;

endmodule
